// File: rtl/grid_move_engine.sv
// grid_move_engine: owns the 4x4 game grid (one 4-bit exponent per cell).
// Executes left/right/up/down moves one line per cycle, spawns a new tile
// after a move that changed the board, and services new-game requests.
// Cell n = y*4+x lives at grid[n*4 +: 4]; 0 = empty, k = tile 2^k.
// rand_val carries the free-running LFSR value sampled on acceptance.
// Optional build macro: GAME_OVER_DETECT_EN adds a 16-cycle CHECK scan
// that raises a sticky game_over when no move is possible.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for new_game / move_valid, ready high unless game over
// LINE   | slide+merge line line_k (0..3) of the captured direction
// SPAWN  | probe cells from probe_p for an empty one and drop a tile
// CHECK  | (GAME_OVER_DETECT_EN only) scan cells for any legal move
// DONE   | one-cycle done pulse with moved, then back to IDLE
module grid_move_engine #(
  parameter int WIN_EXP = 11,
  parameter int MAX_EXP = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic        new_game,
  input  logic [7:0]  rand_val,
  output logic        ready,
  output logic [63:0] grid,
  output logic        done,
  output logic        moved,
  output logic        won,
  output logic        game_over
);

  localparam logic [3:0] WIN_V = 4'(WIN_EXP);
  localparam logic [3:0] MAX_V = 4'(MAX_EXP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE,
    S_SPAWN,
`ifdef GAME_OVER_DETECT_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  dir_q;
  logic [7:0]  rand_q;
  logic        ng_q;
  logic        ng_first;
  logic [1:0]  line_k;
  logic        moved_acc;
  logic [3:0]  probe_p;
  logic [3:0]  probe_cnt;

  logic [3:0]  line_idx [4];
  logic [15:0] line_old;
  logic [15:0] line_new;
  logic        line_changed;
  logic        line_won;
  logic [3:0]  spawn_cell;
  logic [3:0]  spawn_val;

  // Element i of line k for direction d; element 0 is the slide target.
  function automatic logic [3:0] cell_index(input logic [1:0] d,
                                            input logic [1:0] k,
                                            input logic [1:0] i);
    logic [1:0] x;
    logic [1:0] y;
    case (d)
      2'd0:    begin x = i;  y = k;  end
      2'd1:    begin x = ~i; y = k;  end
      2'd2:    begin x = k;  y = i;  end
      default: begin x = k;  y = ~i; end
    endcase
    return {y, x};
  endfunction

  // Compress nonzero tiles to the front, then merge equal pairs front to
  // back; a merged tile is skipped so it cannot merge again this move.
  function automatic logic [15:0] slide_line(input logic [15:0] in);
    logic [3:0]  c [5];
    logic [15:0] out;
    logic [2:0]  n;
    logic [2:0]  j;
    logic        skip;
    for (int i = 0; i < 5; i++) c[i] = 4'd0;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (in[i*4 +: 4] != 4'd0) begin
        c[n] = in[i*4 +: 4];
        n = n + 3'd1;
      end
    end
    out  = '0;
    j    = 3'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 4'd0) begin
        if (c[i] == c[i+1] && c[i] != MAX_V) begin
          out[{j[1:0], 2'b00} +: 4] = c[i] + 4'd1;
          skip = 1'b1;
        end else begin
          out[{j[1:0], 2'b00} +: 4] = c[i];
        end
        j = j + 3'd1;
      end
    end
    return out;
  endfunction

  // Gather the current line, compute its slid/merged replacement.
  always_comb begin
    line_old = '0;
    line_won = 1'b0;
    for (int i = 0; i < 4; i++) begin
      line_idx[i] = cell_index(dir_q, line_k, 2'(i));
      line_old[i*4 +: 4] = grid[{line_idx[i], 2'b00} +: 4];
    end
    line_new     = slide_line(line_old);
    line_changed = (line_new != line_old);
    for (int i = 0; i < 4; i++) begin
      if (line_new[i*4 +: 4] >= WIN_V) line_won = 1'b1;
    end
  end

  // Spawn probe: cell under the pointer and the tile value to drop.
  always_comb begin
    spawn_cell = grid[{probe_p, 2'b00} +: 4];
    spawn_val  = (ng_q || rand_q[7:4] != 4'd0) ? 4'd1 : 4'd2;
  end

`ifdef GAME_OVER_DETECT_EN
  logic [3:0] chk_cnt;
  logic       chk_live;
  logic       chk_cell_live;
  logic       go_q;
  logic [3:0] chk_cur;
  logic [3:0] chk_right;
  logic [3:0] chk_down;

  // A cell offers a move if it is empty or equals its right/lower neighbour.
  always_comb begin
    chk_cur       = grid[{chk_cnt, 2'b00} +: 4];
    chk_right     = grid[{chk_cnt + 4'd1, 2'b00} +: 4];
    chk_down      = grid[{chk_cnt + 4'd4, 2'b00} +: 4];
    chk_cell_live = (chk_cur == 4'd0) ||
                    (chk_cnt[1:0] != 2'd3 && chk_cur == chk_right) ||
                    (chk_cnt[3:2] != 2'd3 && chk_cur == chk_down);
  end

  assign game_over = go_q;
`else
  assign game_over = 1'b0;
`endif

  // Main sequencer: request acceptance, line updates, spawn, status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grid      <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      moved     <= 1'b0;
      won       <= 1'b0;
      dir_q     <= 2'd0;
      rand_q    <= 8'd0;
      ng_q      <= 1'b0;
      ng_first  <= 1'b0;
      line_k    <= 2'd0;
      moved_acc <= 1'b0;
      probe_p   <= 4'd0;
      probe_cnt <= 4'd0;
`ifdef GAME_OVER_DETECT_EN
      chk_cnt   <= 4'd0;
      chk_live  <= 1'b0;
      go_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (new_game) begin
            grid      <= '0;
            won       <= 1'b0;
`ifdef GAME_OVER_DETECT_EN
            go_q      <= 1'b0;
`endif
            rand_q    <= rand_val;
            dir_q     <= move_dir;
            ng_q      <= 1'b1;
            ng_first  <= 1'b1;
            moved_acc <= 1'b1;
            probe_p   <= rand_val[3:0];
            probe_cnt <= 4'd15;
            ready     <= 1'b0;
            state     <= S_SPAWN;
          end else if (move_valid && !game_over) begin
            rand_q    <= rand_val;
            dir_q     <= move_dir;
            ng_q      <= 1'b0;
            ng_first  <= 1'b0;
            moved_acc <= 1'b0;
            line_k    <= 2'd0;
            ready     <= 1'b0;
            state     <= S_LINE;
          end
        end

        S_LINE: begin
          for (int i = 0; i < 4; i++) begin
            grid[{line_idx[i], 2'b00} +: 4] <= line_new[i*4 +: 4];
          end
          if (line_changed) moved_acc <= 1'b1;
          if (line_won) won <= 1'b1;
          line_k <= line_k + 2'd1;
          if (line_k == 2'd3) begin
            if (moved_acc || line_changed) begin
              probe_p   <= rand_q[3:0];
              probe_cnt <= 4'd15;
              state     <= S_SPAWN;
            end else begin
`ifdef GAME_OVER_DETECT_EN
              chk_cnt  <= 4'd15;
              chk_live <= 1'b0;
              state    <= S_CHECK;
`else
              done  <= 1'b1;
              moved <= 1'b0;
              state <= S_DONE;
`endif
            end
          end
        end

        S_SPAWN: begin
          if (spawn_cell == 4'd0 || probe_cnt == 4'd0) begin
            // A full board after 16 probes simply skips the spawn.
            if (spawn_cell == 4'd0) grid[{probe_p, 2'b00} +: 4] <= spawn_val;
            if (ng_q && ng_first) begin
              ng_first  <= 1'b0;
              probe_p   <= rand_q[7:4];
              probe_cnt <= 4'd15;
            end else begin
`ifdef GAME_OVER_DETECT_EN
              chk_cnt  <= 4'd15;
              chk_live <= 1'b0;
              state    <= S_CHECK;
`else
              done  <= 1'b1;
              moved <= moved_acc;
              state <= S_DONE;
`endif
            end
          end else begin
            probe_p   <= probe_p + 4'd1;
            probe_cnt <= probe_cnt - 4'd1;
          end
        end

`ifdef GAME_OVER_DETECT_EN
        S_CHECK: begin
          if (chk_cell_live) chk_live <= 1'b1;
          chk_cnt <= chk_cnt - 4'd1;
          if (chk_cnt == 4'd0) begin
            go_q  <= !(chk_live || chk_cell_live);
            done  <= 1'b1;
            moved <= moved_acc;
            state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          moved <= 1'b0;
          ready <= !game_over;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_move_engine.sv
// tb_grid_move_engine: directed game sequences built from new-game and
// move operations, with hand-computed grids after every operation.
// The engine runs with WIN_EXP=3 and MAX_EXP=3 so won and the no-merge
// ceiling are reachable within a few moves.
module tb_grid_move_engine;

  logic        clk;
  logic        rst;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        new_game;
  logic [7:0]  rand_val;
  logic        ready;
  logic [63:0] grid;
  logic        done;
  logic        moved;
  logic        won;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_R = 2'd1;
  localparam logic [1:0] D_U = 2'd2;
  localparam logic [1:0] D_D = 2'd3;

`ifdef GAME_OVER_DETECT_EN
  localparam int NOMOVE_LAT = 20;
`else
  localparam int NOMOVE_LAT = 4;
`endif

  grid_move_engine #(.WIN_EXP(3), .MAX_EXP(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .new_game   (new_game),
    .rand_val   (rand_val),
    .ready      (ready),
    .grid       (grid),
    .done       (done),
    .moved      (moved),
    .won        (won),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One operation: request, a spurious move_valid while busy, wait for done.
  task automatic run_op(input int row, input logic ng, input logic [1:0] dir,
                        input logic [7:0] r, input logic [63:0] exp_grid,
                        input logic exp_moved, input logic exp_won, input int exp_lat);
    int lat;
    logic seen;
    @(negedge clk);
    check($sformatf("ready_idle%0d", row), 64'(ready), 64'd1);
    new_game   = ng;
    move_valid = 1'b1;
    move_dir   = dir;
    rand_val   = r;
    @(posedge clk); #1;
    new_game   = 1'b0;
    move_valid = 1'b1;
    move_dir   = dir ^ 2'd1;
    rand_val   = 8'hFF;
    check($sformatf("ready_busy%0d", row), 64'(ready), 64'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      move_valid = 1'b0;
      if (done) seen = 1'b1;
    end
    check($sformatf("done_seen%0d", row), 64'(seen), 64'd1);
    if (seen) begin
      check($sformatf("grid%0d", row), grid, exp_grid);
      check($sformatf("moved%0d", row), 64'(moved), 64'(exp_moved));
      check($sformatf("won%0d", row), 64'(won), 64'(exp_won));
      check($sformatf("game_over%0d", row), 64'(game_over), 64'd0);
      if (exp_lat > 0) check($sformatf("latency%0d", row), 64'(lat), 64'(exp_lat));
      @(posedge clk); #1;
      check($sformatf("done_drop%0d", row), 64'(done), 64'd0);
      check($sformatf("ready_back%0d", row), 64'(ready), 64'd1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    move_valid = 1'b0;
    move_dir   = 2'd0;
    new_game   = 1'b0;
    rand_val   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grid", grid, 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_won", 64'(won), 64'd0);
    check("rst_go", 64'(game_over), 64'd0);
    rst = 1'b0;

    // Game A: slides, a merge, a no-move, and the first tile reaching won.
    run_op( 1, 1'b1, D_L, 8'h35, 64'h0000_0000_0010_1000, 1'b1, 1'b0, 0);
    run_op( 2, 1'b0, D_L, 8'h14, 64'h0000_0000_0011_0001, 1'b1, 1'b0, 0);
    run_op( 3, 1'b0, D_L, 8'h00, 64'h0000_0000_0002_0021, 1'b1, 1'b0, 0);
    run_op( 4, 1'b0, D_U, 8'h00, 64'h0000_0000_0002_0021, 1'b0, 1'b0, NOMOVE_LAT);
    run_op( 5, 1'b0, D_D, 8'h1F, 64'h1022_0001_0000_0000, 1'b1, 1'b0, 0);
    run_op( 6, 1'b0, D_L, 8'h2F, 64'h1013_0001_0000_0000, 1'b1, 1'b1, 0);
    run_op( 7, 1'b0, D_R, 8'h30, 64'h2300_1000_0000_0001, 1'b1, 1'b1, 0);

    // Game B: tile-4 spawns, gap merges, and pairs at MAX_EXP refusing to merge.
    run_op( 8, 1'b1, D_L, 8'h10, 64'h0000_0000_0000_0011, 1'b1, 1'b0, 0);
    run_op( 9, 1'b0, D_L, 8'h01, 64'h0000_0000_0000_0022, 1'b1, 1'b0, 0);
    run_op(10, 1'b0, D_L, 8'h01, 64'h0000_0000_0000_0023, 1'b1, 1'b1, 0);
    run_op(11, 1'b0, D_R, 8'h00, 64'h0000_0000_0000_2302, 1'b1, 1'b1, 0);
    run_op(12, 1'b0, D_R, 8'h00, 64'h0000_0000_0000_2322, 1'b1, 1'b1, 0);
    run_op(13, 1'b0, D_L, 8'h03, 64'h0000_0000_0000_2233, 1'b1, 1'b1, 0);
    run_op(14, 1'b0, D_L, 8'h03, 64'h0000_0000_0000_2333, 1'b1, 1'b1, 0);
    run_op(15, 1'b0, D_L, 8'h00, 64'h0000_0000_0000_2333, 1'b0, 1'b1, NOMOVE_LAT);

    // Reset in the middle of LINE aborts back to the reset state.
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = D_L;
    rand_val   = 8'h00;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 64'(ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_grid", grid, 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_won", 64'(won), 64'd0);
    check("abort_moved", 64'(moved), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_grid", grid, 64'd0);
    check("abort_idle_ready", 64'(ready), 64'd1);

    // Game C: a full row of equal tiles merges into two pairs.
    run_op(16, 1'b1, D_R, 8'h10, 64'h0000_0000_0000_0011, 1'b1, 1'b0, 0);
    run_op(17, 1'b0, D_D, 8'h12, 64'h0011_0000_0000_0100, 1'b1, 1'b0, 0);
    run_op(18, 1'b0, D_D, 8'h13, 64'h0111_0000_0000_1000, 1'b1, 1'b0, 0);
    run_op(19, 1'b0, D_D, 8'h10, 64'h1111_0000_0000_0001, 1'b1, 1'b0, 0);
    run_op(20, 1'b0, D_L, 8'h1F, 64'h1022_0000_0000_0001, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grid_move_engine.md
Name: grid_move_engine

Overview:
- Owns the 64-bit game grid and is the only writer of it. The pixel renderer only reads it.
- Accepts a move command (left/right/up/down), then slides and merges tiles one line per cycle.
- Spawns a new tile in an empty cell when the board changed, then reports done/moved/won status to the input/controller logic.
- Also services new-game requests: clears the board and spawns two tiles.

Parameters:
- WIN_EXP, 11, tile exponent that sets won (11 = 2048).
- MAX_EXP, 15, largest exponent; two MAX_EXP tiles never merge.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- move_valid  in  1  move request
- move_dir  in  2  0=left 1=right 2=up 3=down
- new_game  in  1  start new game request
- rand  in  8  free-running random value from LFSR
- ready  out  1  high in IDLE; request accepted when request && ready
- grid  out  64  cell n at grid[n*4 +: 4], n = y*4+x; 0=empty, k=tile 2^k
- done  out  1  one-cycle pulse at end of any move/new-game operation
- moved  out  1  valid with done; 1 if grid changed by slide/merge
- won  out  1  sticky; set when any cell reaches WIN_EXP
- game_over  out  1  sticky; see Optional Feature

Behaviour:
- Interface: clk, synchronous active-high rst; everything samples on the rising edge of clk.
- Reset: grid=0, state=IDLE, ready=1, done=0, moved=0, won=0, game_over=0. rst mid-operation aborts immediately to these values.
- States: IDLE, LINE, SPAWN, DONE.
  - ready = (state==IDLE) && !game_over. new_game is also accepted in IDLE when game_over=1.
- Acceptance edge E0:
  - new_game has priority over move_valid in the same cycle.
  - Capture move_dir and rand. Clear the internal moved flag.
- new_game path:
  - E0 clears grid and clears won/game_over.
  - Goes to SPAWN twice: first probe start = rand[3:0], second start = captured rand[7:4].
  - Then DONE. moved=1 with done.
- LINE (edges E1..E4, line k=0..3 written at E(k+1)):
  - Line k cell order, first element is the slide target:
    - left: (x=0..3, y=k)
    - right: (x=3..0, y=k)
    - up: (x=k, y=0..3)
    - down: (x=k, y=3..0)
  - Compress nonzero cells toward the front, preserving order.
  - Merge adjacent equal pairs scanning from the front. Each tile merges at most once per move.
  - A merged value is v+1. Pairs with v==MAX_EXP do not merge.
  - Pad with 0. The line is written back the same cycle.
  - moved |= (new line != old line).
  - won set if any written value >= WIN_EXP.
  - After E4: if moved, go to SPAWN; else go to DONE.
- Grid visibility: grid updates line-by-line and is visible mid-operation. The renderer tolerates this.
- SPAWN:
  - Probe pointer p starts at captured rand[3:0] and increments mod 16, one cell per cycle.
  - First empty cell gets 1 (tile 2), or 2 (tile 4) if captured rand[7:4]==0. For the new-game spawns, use 1 always.
  - If 16 probes find no empty cell, skip the spawn and go on (a valid move always frees a cell, so this is a guard only).
- DONE: done=1 and moved valid for exactly one cycle, then IDLE.
- Requests while busy are ignored (not queued). won stays set until new_game or rst.

Optional Feature:
- Macro: GAME_OVER_DETECT_EN.
- Enabled:
  - A CHECK state runs after SPAWN (or after LINE when there was no move).
  - It scans the 16 cells over 16 cycles.
  - game_over is set if no cell is 0 and no horizontally or vertically adjacent pair is equal.
  - done pulses after CHECK. Once game_over=1, move_valid is refused until new_game.
- Disabled: no CHECK state; game_over is tied 0.

Test Plan:
- Merge: grid=64'h0000_0000_0000_2211, rand=8'h14, move left → done pulse, moved=1, grid=64'h0000_0000_0001_0032.
- Double merge: row0=[2,2,2,2] (grid=64'h2222), rand=8'h1F, move left → row0=[3,3,0,0], tile 1 at cell 15; grid=64'h1000_0000_0000_0033.
- Gap merge and no-move:
  - row0=[1,0,0,1], move right → row0=[0,0,0,2].
  - Then row0=[1,2,3,4] only, move left → moved=0, grid unchanged, done high in cycle after E4.
- Vertical and won: column0 cells y=0..3 = [A,A,0,0], move down → cell 12 = B, won=1.
  - MAX_EXP: column [F,F,0,0] down → [0,0,F,F] (no merge), moved=1.
- new_game and reset:
  - new_game with rand=8'h35 → cells 5 and 3 = 1, others 0, moved=1.
  - rst asserted during LINE → grid=0, ready=1 next cycle. move_valid during LINE is ignored.
- GAME_OVER_DETECT_EN: checkerboard of 1/2 full board with a move that changes nothing → game_over=1, ready=0; new_game clears it.
